// File: rtl/gpio_irq_ctrl.sv
// GPIO input controller: prescaled sampling, per-bit glitch filter, edge detection,
// sticky pending flags and a registered interrupt. Optional level events: GPIO_IRQ_LEVEL_EN.
module gpio_irq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16,
    parameter int FILTER_LEN = 3
) (
    input  logic                  io_mainClk,
    input  logic                  resetCtrl_systemReset,
    input  logic [WIDTH-1:0]      io_syncIn,
    input  logic [PRESCALE_W-1:0] io_prescale,
    input  logic [WIDTH-1:0]      io_riseEn,
    input  logic [WIDTH-1:0]      io_fallEn,
    input  logic                  io_clrValid,
    input  logic [WIDTH-1:0]      io_clrMask,
`ifdef GPIO_IRQ_LEVEL_EN
    input  logic [WIDTH-1:0]      io_levelEn,
    input  logic [WIDTH-1:0]      io_levelPol,
`endif
    output logic [WIDTH-1:0]      io_filtered,
    output logic [WIDTH-1:0]      io_pending,
    output logic                  io_irq
);

    typedef enum logic {PRIME, RUN} state_t;

    localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                           state;
    logic [PRESCALE_W-1:0]            cnt;
    logic [FILTER_LEN-1:0][WIDTH-1:0] hist;

    logic                             tick;
    logic [FILTER_LEN-1:0][WIDTH-1:0] hist_shift;
    logic [WIDTH-1:0]                 all_one;
    logic [WIDTH-1:0]                 all_zero;
    logic [WIDTH-1:0]                 new_filtered;
    logic [WIDTH-1:0]                 rise;
    logic [WIDTH-1:0]                 fall;
    logic [WIDTH-1:0]                 level_set;
    logic [WIDTH-1:0]                 set_bits;
    logic [WIDTH-1:0]                 clr_bits;

    // A bit only moves once every history slot, newest sample included, agrees.
    always_comb begin
        tick       = (cnt >= io_prescale);
        hist_shift = {hist[FILTER_LEN-2:0], io_syncIn};
        all_one    = '1;
        all_zero   = '1;
        for (int k = 0; k < FILTER_LEN; k++) begin
            all_one  = all_one & hist_shift[k];
            all_zero = all_zero & ~hist_shift[k];
        end
        new_filtered = (io_filtered | all_one) & ~all_zero;
        rise         = new_filtered & ~io_filtered;
        fall         = ~new_filtered & io_filtered;
`ifdef GPIO_IRQ_LEVEL_EN
        level_set    = io_levelEn & ~(io_filtered ^ io_levelPol);
`else
        level_set    = '0;
`endif
        set_bits     = '0;
        if (tick && state == RUN) begin
            set_bits = (rise & io_riseEn) | (fall & io_fallEn) | level_set;
        end
        clr_bits     = io_clrValid ? io_clrMask : '0;
    end

    always_ff @(posedge io_mainClk) begin
        if (resetCtrl_systemReset) begin
            state       <= PRIME;
            cnt         <= '0;
            hist        <= '0;
            io_filtered <= '0;
            io_pending  <= '0;
            io_irq      <= 1'b0;
        end else begin
            cnt        <= tick ? '0 : cnt + CNT_ONE;
            io_pending <= (io_pending & ~clr_bits) | set_bits;
            io_irq     <= |io_pending;
            if (tick) begin
                unique case (state)
                    PRIME: begin
                        hist        <= {FILTER_LEN{io_syncIn}};
                        io_filtered <= io_syncIn;
                        state       <= RUN;
                    end
                    RUN: begin
                        hist        <= hist_shift;
                        io_filtered <= new_filtered;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/gpio_irq_ctrl.md
Name: gpio_irq_ctrl

Overview:
Input-side controller for the GPIO bank. It sits directly after the two-flop input synchronizer, on the same clock. A programmable prescaler sequences sampling of the synchronized pins. Each sample runs through a per-bit glitch filter and edge detection, and detected edges set sticky per-bit pending flags. The flags are cleared through a mask/valid handshake and combined into one registered interrupt line for the APB GPIO peripheral.

Parameters:
WIDTH, 32, number of GPIO bits handled
PRESCALE_W, 16, width of prescaler counter and compare value
FILTER_LEN, 3, consecutive identical samples (>=2) required to accept a new level

Ports:
io_mainClk  input  1  system clock
resetCtrl_systemReset  input  1  synchronous, active-high reset
io_syncIn  input  WIDTH  already-synchronized pin levels
io_prescale  input  PRESCALE_W  sample period minus one, in clocks
io_riseEn  input  WIDTH  per-bit rising-edge event enable
io_fallEn  input  WIDTH  per-bit falling-edge event enable
io_clrValid  input  1  clear request strobe, one cycle
io_clrMask  input  WIDTH  bits to clear when io_clrValid=1
io_filtered  output  WIDTH  debounced pin levels
io_pending  output  WIDTH  sticky event flags
io_irq  output  1  registered OR of io_pending

Behaviour:
Clock and reset:
- One clock, io_mainClk. Reset is synchronous and active-high on resetCtrl_systemReset.
- Reset values: prescaler cnt=0, sample history=0, io_filtered=0, io_pending=0, io_irq=0, state=PRIME.
- Reset asserted mid-operation discards all history and pending flags on the next edge.

Prescaler:
- tick=1 when cnt>=io_prescale; cnt then loads 0. Otherwise cnt increments.
- io_prescale=0 gives a tick every cycle.
- Lowering io_prescale below the current cnt produces a tick on the next cycle (>= compare); there is no counter wrap-through.

State machine (2 states):
- PRIME: on the first tick, load all FILTER_LEN history slots and io_filtered with io_syncIn. No edge events. Go to RUN.
- RUN: on each tick, shift io_syncIn into the history (FILTER_LEN deep, per bit).
- A bit's filtered value changes only when all FILTER_LEN history entries (including the new sample) are equal and differ from the current io_filtered. Otherwise it holds.
- Between ticks, history and io_filtered hold.

Events:
- rise = new_filtered & ~io_filtered; fall = ~new_filtered & io_filtered. Both are evaluated in the tick cycle.
- io_pending_next = (io_pending & ~(io_clrValid ? io_clrMask : 0)) | (rise & io_riseEn) | (fall & io_fallEn).
- Set and clear on the same bit in the same cycle: set wins.
- io_clrValid has no ready; it is always accepted in one cycle.
- Changing enables does not retroactively set or clear pending.

Latency:
- io_filtered and io_pending update on the same edge, FILTER_LEN ticks after a stable change on io_syncIn.
- io_irq follows io_pending by exactly one cycle, and deasserts one cycle after the last pending bit clears.

Widths: cnt is PRESCALE_W bits unsigned. All per-bit logic is independent across WIDTH.

Optional Feature:
GPIO_IRQ_LEVEL_EN:
- Defined: adds inputs io_levelEn (WIDTH) and io_levelPol (WIDTH).
- In RUN, on every tick, each bit with io_levelEn=1 and io_filtered==io_levelPol sets its pending bit.
- Because set beats clear, a clear only takes effect once the level condition is gone or between ticks.
- Level sets are ORed with edge sets.
- Not defined: the ports are absent and only edge events exist.

Test Plan:
- Reset, then io_syncIn=32'h0000_00FF, io_prescale=0, riseEn=all -> after first tick io_filtered=32'hFF, io_pending=0, io_irq stays 0 (PRIME, no events).
- Bit 8 driven 0->1 and held, prescale=0, FILTER_LEN=3 -> io_filtered[8]=1 and io_pending[8]=1 exactly 3 cycles after the change; io_irq=1 one cycle later.
- Bit 8 pulsed high for 2 ticks only (FILTER_LEN=3), prescale=4 -> io_filtered[8] stays 0, no pending; prescaler ticks every 5 cycles.
- io_pending=32'h0000_0101, then clrValid with clrMask=32'h1 -> pending=32'h100 next cycle, io_irq stays 1. Clear 32'h100 -> pending=0, io_irq=0 one cycle later.
- Falling edge on bit 3 with fallEn[3]=1, coinciding with clrValid mask=32'h8 in the same cycle -> io_pending[3]=1 (set wins).
- Reset asserted while pending=32'hFFFF and mid-count -> next edge all outputs 0, state=PRIME, and the next tick reseeds with no events.
